// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the register file / scoreboard block: default data and
// flags widths and the bit positions of the CLFZN processor flags.
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FLAG_W_DEF = 5;

    // CLFZN flags register bit order
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard_if
// Bus between the datapath control (master) and the register file (slave).
//   write port : wr_en, wr_addr, wr_data
//   read port A: rd_addr_a -> rd_data_a, busy_a   (combinational)
//   read port B: rd_addr_b -> rd_data_b, busy_b   (combinational)
//   scoreboard : busy_set, busy_addr
//   flags      : flags_en, flags_in -> flags      (registered)
// Handshake: there is no valid/ready pair. Every strobe (wr_en, busy_set,
// flags_en) is a single-cycle request sampled on the rising clock edge and is
// always accepted; the master stalls itself by watching busy_a/busy_b.
// -----------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [DATA_W-1:0] rd_data_a;
    logic              busy_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_b;
    logic              busy_b;
    logic              busy_set;
    logic [ADDR_W-1:0] busy_addr;
    logic              flags_en;
    logic [FLAG_W-1:0] flags_in;
    logic [FLAG_W-1:0] flags;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               busy_set, busy_addr, flags_en, flags_in,
        input  rd_data_a, busy_a, rd_data_b, busy_b, flags
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
               busy_set, busy_addr, flags_en, flags_in,
        output rd_data_a, busy_a, rd_data_b, busy_b, flags
    );
endinterface

// File: rtl/regfile_busy_tracker.sv
// -----------------------------------------------------------------------------
// regfile_busy_tracker
// One pending bit per register for multi-cycle producers.
//   clk, reset             : clock, async active-high reset (clears all bits)
//   clr_en, clr_addr       : a completed write clears its bit
//   set_en, set_addr       : a newly issued producer sets its bit
//   look_a_addr/look_b_addr: lookup addresses
//   busy_a/busy_b          : registered bit at the lookup address
// Callers pre-qualify clr_en/set_en (range, hardwired zero). Lookups outside
// 0..NUM_REGS-1 return 0.
// -----------------------------------------------------------------------------
module regfile_busy_tracker #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic [ADDR_W-1:0] look_a_addr,
    input  logic [ADDR_W-1:0] look_b_addr,
    output logic              busy_a,
    output logic              busy_b
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (clr_en && (clr_addr == ADDR_W'(i))) busy_d[i] = 1'b0;
            // Applied after the clear: a new producer issued on the same edge
            // as the old result lands keeps the register pending.
            if (set_en && (set_addr == ADDR_W'(i))) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    always_comb begin
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (look_a_addr == ADDR_W'(i)) busy_a = busy_q[i];
            if (look_b_addr == ADDR_W'(i)) busy_b = busy_q[i];
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Addressed register file: one write port, two combinational read ports,
// optional write-to-read bypass, optional hardwired-zero r0, a per-register
// busy scoreboard and the CLFZN flags register.
//   clk   : rising-edge clock
//   reset : asynchronous active-high; clears registers, busy bits and flags
//           and forces all read outputs to 0 while held
//   bus   : regfile_scoreboard_if.slave (write, two reads, busy_set, flags)
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_REG = 1'b0,
    parameter bit BYPASS   = 1'b1,
    parameter int FLAG_W   = FLAG_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_scoreboard_if.slave  bus
);

    // Address names a real, writable register (in range and not hardwired r0).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < NUM_REGS) && !(ZERO_REG && (addr == '0));
    endfunction

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;

    logic              wr_ok;
    logic              set_ok;
    logic              rd_ok_a;
    logic              rd_ok_b;
    logic [DATA_W-1:0] raw_a;
    logic [DATA_W-1:0] raw_b;
    logic              trk_busy_a;
    logic              trk_busy_b;

    // Qualified requests. Gating with reset also keeps the bypass path from
    // leaking wr_data onto the read ports while reset is held.
    always_comb begin
        wr_ok   = !reset && bus.wr_en && addr_ok(bus.wr_addr);
        set_ok  = !reset && bus.busy_set && addr_ok(bus.busy_addr);
        rd_ok_a = !reset && addr_ok(bus.rd_addr_a);
        rd_ok_b = !reset && addr_ok(bus.rd_addr_b);
    end

    // Storage next state
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_ok && (bus.wr_addr == ADDR_W'(i))) regs_d[i] = bus.wr_data;
        end
    end

    always_comb begin
        flags_d = bus.flags_en ? bus.flags_in : flags_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    regfile_busy_tracker #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_busy (
        .clk         (clk),
        .reset       (reset),
        .clr_en      (wr_ok),
        .clr_addr    (bus.wr_addr),
        .set_en      (set_ok),
        .set_addr    (bus.busy_addr),
        .look_a_addr (bus.rd_addr_a),
        .look_b_addr (bus.rd_addr_b),
        .busy_a      (trk_busy_a),
        .busy_b      (trk_busy_b)
    );

    // Raw array lookups; out-of-range addresses fall through to 0.
    always_comb begin
        raw_a = '0;
        raw_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_addr_a == ADDR_W'(i)) raw_a = regs_q[i];
            if (bus.rd_addr_b == ADDR_W'(i)) raw_b = regs_q[i];
        end
    end

    // Read ports. A bypassed read reports not-busy: the value on wr_data is
    // the result the pending bit was waiting for.
    always_comb begin
        bus.rd_data_a = '0;
        bus.busy_a    = 1'b0;
        if (rd_ok_a) begin
            if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_a)) begin
                bus.rd_data_a = bus.wr_data;
            end else begin
                bus.rd_data_a = raw_a;
                bus.busy_a    = trk_busy_a;
            end
        end
    end

    always_comb begin
        bus.rd_data_b = '0;
        bus.busy_b    = 1'b0;
        if (rd_ok_b) begin
            if (BYPASS && wr_ok && (bus.wr_addr == bus.rd_addr_b)) begin
                bus.rd_data_b = bus.wr_data;
            end else begin
                bus.rd_data_b = raw_b;
                bus.busy_b    = trk_busy_b;
            end
        end
    end

    always_comb begin
        bus.flags = flags_q;
    end

endmodule
